axi_master_rd: RTL and testbench

AXI_MASTER_RD -- requirements
Module: axi_master_rd

---
 rtl/axi_master_rd.sv | 104 ++++++++++
 tb/tb_axi_master_rd.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_rd.sv
// AXI4 read master: issues one INCR burst per rd_start and streams the R beats
// back as registered rd_data/rd_data_valid, ending with a one-cycle rd_done/rd_err.
module axi_master_rd #(
  parameter int         AXI_WIDTH  = 64,
  parameter logic [2:0] AXI_AXSIZE = 3'b011,
  parameter int         ADDR_WIDTH = 30
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_start,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [7:0]            rd_len,
  output logic                  rd_ready,
  output logic [AXI_WIDTH-1:0]  rd_data,
  output logic                  rd_data_valid,
  output logic                  rd_done,
  output logic                  rd_err,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [AXI_WIDTH-1:0]  m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]            arlen_q;
  logic [7:0]            beat_cnt;
  logic                  err_q;
  logic                  mismatch;

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are
  // both high. arvalid/araddr/arlen stay fixed from AR entry until arready; rready
  // is high for the whole R state, so every rvalid cycle in R is an accepted beat.

  // rlast must land exactly on beat arlen; a beat at arlen without rlast also counts.
  assign mismatch = m_axi_rlast ? (beat_cnt != arlen_q) : (beat_cnt == arlen_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      araddr_q      <= '0;
      arlen_q       <= '0;
      beat_cnt      <= '0;
      err_q         <= 1'b0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rd_start) begin
            araddr_q <= rd_addr;
            arlen_q  <= rd_len;
            err_q    <= 1'b0;
            state    <= S_AR;
          end
        end
        S_AR: begin
          if (m_axi_arready) begin
            beat_cnt <= '0;
            state    <= S_R;
          end
        end
        S_R: begin
          if (m_axi_rvalid) begin
            rd_data       <= m_axi_rdata;
            rd_data_valid <= 1'b1;
            beat_cnt      <= beat_cnt + 8'd1;
            if ((m_axi_rresp != 2'b00) || mismatch) begin
              err_q <= 1'b1;
            end
            if (m_axi_rlast) begin
              state <= S_DONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rd_ready      = (state == S_IDLE);
  assign rd_done       = (state == S_DONE);
  assign rd_err        = (state == S_DONE) && err_q;
  assign m_axi_arvalid = (state == S_AR);
  assign m_axi_rready  = (state == S_R);
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = AXI_AXSIZE;
  assign m_axi_arburst = 2'b01;

endmodule

// File: tb/tb_axi_master_rd.sv
// Bench for axi_master_rd: a table of directed bursts, hold-start and mid-burst
// reset sequences, then random bursts checked against a transaction-level model.
module tb_axi_master_rd;

  localparam int BUDGET = 700;
  localparam int MAXB   = 300;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_start;
  logic [29:0] rd_addr;
  logic [7:0]  rd_len;
  logic        rd_ready;
  logic [63:0] rd_data;
  logic        rd_data_valid;
  logic        rd_done;
  logic        rd_err;
  logic [29:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  axi_master_rd dut (
    .clk(clk), .rst_n(rst_n),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_done(rd_done), .rd_err(rd_err),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int          n_pass  = 0;
  int          n_total = 0;
  logic [63:0] exp_q[$];
  logic [63:0] beat_data [MAXB];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic load_data(input int nbeats);
    exp_q.delete();
    for (int i = 0; i < nbeats; i++) begin
      beat_data[i] = {$urandom, $urandom};
      exp_q.push_back(beat_data[i]);
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ctrl"}, {58'd0, rd_ready, m_axi_arvalid, m_axi_rready, rd_data_valid, rd_done, rd_err},
          64'b100000);
    check({tag, "_data"}, rd_data, 64'd0);
    check({tag, "_ar"}, {26'd0, m_axi_araddr, m_axi_arlen}, 64'd0);
  endtask

  // driver: launches one burst and plays the slave side until rd_done (or abort)
  task automatic do_burst(input logic [29:0] addr, input logic [7:0] len, input int nbeats,
                          input int err_beat, input int ar_wait, input int gap_pct,
                          input bit hold, input int abort_at, input bit exp_err, input int exp_lat);
    int k, ar_seen, beat_i, ar_hs, viol, unstable, lat, nd;
    bit ar_ok, ar_started, hs_ar, hs_r, done_seen, err_seen, valid_at_done, aborted;
    k = 0; ar_seen = 0; beat_i = 0; ar_hs = 0; viol = 0; unstable = 0; lat = 0;
    ar_ok = 0; ar_started = 0; hs_ar = 0; hs_r = 0; done_seen = 0; err_seen = 0;
    valid_at_done = 0; aborted = 0;
    @(posedge clk); #1;
    rd_start = 1'b1; rd_addr = addr; rd_len = len;
    m_axi_arready = (ar_wait == 0); m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
    while (k < BUDGET) begin
      @(negedge clk);
      k++;
      if (k == 1) check("ready_at_start", rd_ready, 1'b1);
      hs_ar = m_axi_arvalid && m_axi_arready;
      hs_r  = m_axi_rvalid && m_axi_rready;
      if (m_axi_arvalid) begin
        ar_seen++;
        ar_started = 1;
        if (m_axi_araddr != addr || m_axi_arlen != len || m_axi_arsize != 3'b011 ||
            m_axi_arburst != 2'b01) unstable++;
      end
      if (ar_started && !ar_ok && !m_axi_arvalid) viol++;
      if (m_axi_rready && !ar_ok) viol++;
      if (rd_err && !rd_done) viol++;
      if (hs_ar) begin
        ar_hs++;
        check("ar_fields", {21'd0, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst},
              {21'd0, addr, len, 3'b011, 2'b01});
      end
      if (rd_data_valid) begin
        if (exp_q.size() == 0) check("extra_beat", rd_data, 64'd0 - 64'd1);
        else check("beat_data", rd_data, exp_q.pop_front());
      end
      if (rd_done) begin
        done_seen = 1; lat = k; err_seen = rd_err; valid_at_done = rd_data_valid;
        break;
      end
      @(posedge clk); #1;
      if (hold) rd_addr = addr ^ 30'h3f0;
      else rd_start = 1'b0;
      if (hs_ar) ar_ok = 1;
      if (hs_r) beat_i++;
      if (abort_at >= 0 && beat_i == abort_at) begin
        rst_n = 1'b0; rd_start = 1'b0; m_axi_rvalid = 1'b0; m_axi_arready = 1'b0;
        #1;
        reset_checks("abort_rst");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        nd = 0;
        repeat (20) begin
          @(negedge clk);
          if (rd_done || rd_data_valid || m_axi_arvalid) nd++;
        end
        check("no_done_after_abort", nd, 0);
        check("idle_after_abort", rd_ready, 1'b1);
        aborted = 1;
        break;
      end
      m_axi_arready = (ar_seen >= ar_wait);
      m_axi_rvalid  = ar_ok && (beat_i < nbeats) && (int'($urandom_range(0, 99)) >= gap_pct);
      m_axi_rdata   = (beat_i < MAXB) ? beat_data[beat_i] : 64'd0;
      m_axi_rresp   = (beat_i == err_beat) ? 2'b10 : 2'b00;
      m_axi_rlast   = (beat_i == nbeats - 1);
    end
    if (!aborted) begin
      check("done_seen", done_seen, 1'b1);
      check("ar_handshakes", ar_hs, 1);
      check("ar_stable", unstable, 0);
      check("protocol", viol, 0);
      check("beats_left", exp_q.size(), 0);
      check("err_with_done", err_seen, exp_err);
      check("last_valid_with_done", valid_at_done, 1'b1);
      if (exp_lat >= 0) check("latency", lat, exp_lat);
      if (!hold) begin
        @(negedge clk);
        check("single_done", {rd_done, rd_ready}, 2'b01);
      end
    end
  endtask

  typedef struct {
    logic [29:0] addr;
    logic [7:0]  len;
    int          nbeats;
    int          err_beat;
    int          ar_wait;
    int          gap;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [29:0] a;
    logic [7:0]  l;
    int          nb, eb, aw, gp, el;
    bit          ee;

    rst_n = 1'b0; rd_start = 1'b0; rd_addr = '0; rd_len = '0;
    m_axi_arready = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
    m_axi_rvalid = 1'b0;
    #1;
    reset_checks("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", rd_ready, 1'b1);

    // addr, len, beats, err beat, ar wait, gap%, exp err, exp latency (-1: unchecked)
    vecs[0] = '{30'h100,      8'd7,   8,   -1, 0, 0,  1'b0, 11};
    vecs[1] = '{30'h2000,     8'd7,   8,   -1, 5, 0,  1'b0, 16};
    vecs[2] = '{30'h3ffffff8, 8'd0,   1,   -1, 0, 0,  1'b0, 4};
    vecs[3] = '{30'h40,       8'd3,   4,    2, 0, 0,  1'b1, 7};
    vecs[4] = '{30'h80,       8'd3,   2,   -1, 0, 0,  1'b1, 5};
    vecs[5] = '{30'hc0,       8'd1,   3,   -1, 0, 0,  1'b1, 6};
    vecs[6] = '{30'h1000,     8'd7,   8,   -1, 0, 50, 1'b0, -1};
    vecs[7] = '{30'h8000,     8'd255, 256, -1, 0, 0,  1'b0, 259};
    for (int i = 0; i < 8; i++) begin
      load_data(vecs[i].nbeats);
      do_burst(vecs[i].addr, vecs[i].len, vecs[i].nbeats, vecs[i].err_beat, vecs[i].ar_wait,
               vecs[i].gap, 1'b0, -1, vecs[i].exp_err, vecs[i].exp_lat);
    end

    // rd_start held through a burst, then a second burst right after rd_done
    load_data(4);
    do_burst(30'h500, 8'd3, 4, -1, 0, 0, 1'b1, -1, 1'b0, 7);
    load_data(2);
    do_burst(30'h600, 8'd1, 2, -1, 0, 0, 1'b0, -1, 1'b0, 5);

    // reset pulse after beat 4 of 8, then a normal burst
    load_data(8);
    do_burst(30'h700, 8'd7, 8, -1, 0, 0, 1'b0, 4, 1'b0, -1);
    load_data(8);
    do_burst(30'h700, 8'd7, 8, -1, 0, 0, 1'b0, -1, 1'b0, 11);

    // random bursts against the transaction-level model
    for (int t = 0; t < 24; t++) begin
      a  = $urandom & 30'h3ffffff8;
      l  = 8'($urandom_range(0, 15));
      nb = ($urandom_range(0, 99) < 80) ? int'(l) + 1 : int'($urandom_range(1, 17));
      eb = ($urandom_range(0, 99) < 20) ? int'($urandom_range(0, nb - 1)) : -1;
      aw = $urandom_range(0, 3);
      gp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 60)) : 0;
      ee = (eb >= 0) || (nb != int'(l) + 1);
      el = (gp == 0) ? nb + 3 + aw : -1;
      load_data(nb);
      do_burst(a, l, nb, eb, aw, gp, 1'b0, -1, ee, el);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
